keypad_scan: RTL and testbench

Scanned 4x4 matrix-keypad reader for the HEROE board, the input-side counterpart of the multiplexed seven-segment display driver. It drives one keypad column low at a time and samples the four row lines. Each full sweep is debounced, and a press of exactly one key is reported as a held code with a valid/ack handshake. The game FSM consumes these codes for menu selection and hero movement.

---
 rtl/heroe_pkg.sv | 55 +++++
 rtl/input_sync.sv | 28 ++
 rtl/keypad_scan.sv | 213 +++++++++++++++++++++
 tb/tb_keypad_scan.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/heroe_pkg.sv
// Shared types and constants for the HEROE board input path: keypad
// scanner state encoding, sweep classification and game key codes.
package heroe_pkg;

    localparam int KEY_W = 4;

    // Keypad debounce FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_PRESS = 2'd1,
        PRESSED  = 2'd2
    } kp_state_t;

    // Classification of one full 16-key sweep
    typedef enum logic [1:0] {
        SW_NONE   = 2'd0,
        SW_SINGLE = 2'd1,
        SW_MULTI  = 2'd2
    } sweep_cls_t;

    typedef struct packed {
        sweep_cls_t       cls;
        logic [KEY_W-1:0] idx;
    } sweep_t;

    // Key codes used by the game FSM, formatted as {col[1:0], row[1:0]}
    localparam logic [KEY_W-1:0] KEY_UP    = 4'h1;
    localparam logic [KEY_W-1:0] KEY_LEFT  = 4'h4;
    localparam logic [KEY_W-1:0] KEY_OK    = 4'h5;
    localparam logic [KEY_W-1:0] KEY_RIGHT = 4'h6;
    localparam logic [KEY_W-1:0] KEY_DOWN  = 4'h9;

    // Count pressed keys in a snapshot; idx is only meaningful for SW_SINGLE
    function automatic sweep_t classify(input logic [15:0] snap);
        sweep_t     res;
        logic [4:0] ones;
        ones    = 5'd0;
        res.idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap[i]) begin
                ones    = ones + 5'd1;
                res.idx = 4'(i);
            end
        end
        if (ones == 5'd0) begin
            res.cls = SW_NONE;
        end else if (ones == 5'd1) begin
            res.cls = SW_SINGLE;
        end else begin
            res.cls = SW_MULTI;
        end
        return res;
    endfunction

endpackage

// File: rtl/input_sync.sv
// Two-flop synchronizer for asynchronous, active-low button/row lines.
// Resets to all-ones so an idle (pulled-up) line reads as not pressed.
module input_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {WIDTH{1'b1}};
            sync_r <= {WIDTH{1'b1}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one column low per slot, snapshots the
// rows, debounces whole sweeps and reports single-key presses via valid/ack.
module keypad_scan
    import heroe_pkg::*;
#(
    parameter int SCAN_DIV = 1350,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ack,
    output logic             key_held,
    output logic             overrun
);

    localparam int                SLOT_W    = $clog2(SCAN_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(32'd1);
    localparam logic [3:0]        DB_MAX    = 4'(DEBOUNCE);

    logic [3:0]        row_sync_s;
    logic [3:0]        row_press_s;
    logic              slot_last_s;
    logic [15:0]       snap_next_s;
    sweep_t            sweep_s;

    logic [SLOT_W-1:0] slot_r;
    logic [1:0]        col_r;
    logic [3:0]        col_out_r;
    logic [15:0]       snap_r;
    logic              sweep_done_r;

    kp_state_t         state_r;
    kp_state_t         state_nx_s;
    logic [KEY_W-1:0]  cand_r;
    logic [KEY_W-1:0]  cand_nx_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_nx_s;
    logic [3:0]        cnt_inc_s;
    logic              press_evt_s;
    logic              held_nx_s;

    logic [KEY_W-1:0]  key_code_r;
    logic              key_valid_r;
    logic              key_held_r;
    logic              overrun_r;

    input_sync #(.WIDTH(4)) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_in),
        .q     (row_sync_s)
    );

    // Rows are active-low: a low line under a driven column is a pressed key
    assign row_press_s = ~row_sync_s;
    assign slot_last_s = (slot_r == SLOT_LAST);
    assign sweep_s     = classify(snap_r);

    // Merge the current column's rows into the snapshot at the end of its slot
    always_comb begin
        snap_next_s = snap_r;
        if (slot_last_s) begin
            snap_next_s[{col_r, 2'b00} +: 4] = row_press_s;
        end else begin
            snap_next_s = snap_r;
        end
    end

    // Slot/column counters, column drive and snapshot register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r       <= {SLOT_W{1'b0}};
            col_r        <= 2'd0;
            col_out_r    <= 4'b1110;
            snap_r       <= 16'h0000;
            sweep_done_r <= 1'b0;
        end else begin
            snap_r       <= snap_next_s;
            sweep_done_r <= slot_last_s && (col_r == 2'd3);
            if (slot_last_s) begin
                slot_r    <= {SLOT_W{1'b0}};
                col_r     <= col_r + 2'd1;
                col_out_r <= ~(4'b0001 << (col_r + 2'd1));
            end else begin
                slot_r    <= slot_r + SLOT_ONE;
            end
        end
    end

    // FSM state register together with candidate key and debounce counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cand_r  <= 4'd0;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nx_s;
            cand_r  <= cand_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Next-state logic: one step per completed sweep
    always_comb begin
        state_nx_s  = state_r;
        cand_nx_s   = cand_r;
        cnt_nx_s    = cnt_r;
        press_evt_s = 1'b0;
        cnt_inc_s   = cnt_r + 4'd1;
        if (sweep_done_r) begin
            case (state_r)
                IDLE: begin
                    if (sweep_s.cls == SW_SINGLE) begin
                        cand_nx_s = sweep_s.idx;
                        if (DB_MAX == 4'd1) begin
                            state_nx_s  = PRESSED;
                            cnt_nx_s    = 4'd0;
                            press_evt_s = 1'b1;
                        end else begin
                            state_nx_s  = DB_PRESS;
                            cnt_nx_s    = 4'd1;
                        end
                    end else begin
                        cnt_nx_s = 4'd0;
                    end
                end
                DB_PRESS: begin
                    if (sweep_s.cls == SW_SINGLE) begin
                        if (sweep_s.idx == cand_r) begin
                            if (cnt_inc_s == DB_MAX) begin
                                state_nx_s  = PRESSED;
                                cnt_nx_s    = 4'd0;
                                press_evt_s = 1'b1;
                            end else begin
                                cnt_nx_s = cnt_inc_s;
                            end
                        end else begin
                            cand_nx_s = sweep_s.idx;
                            cnt_nx_s  = 4'd1;
                        end
                    end else begin
                        state_nx_s = IDLE;
                        cnt_nx_s   = 4'd0;
                    end
                end
                PRESSED: begin
                    // Anything but the held key counts toward release, which
                    // locks out a second key until the first is let go
                    if ((sweep_s.cls == SW_SINGLE) && (sweep_s.idx == cand_r)) begin
                        cnt_nx_s = 4'd0;
                    end else if (cnt_inc_s == DB_MAX) begin
                        state_nx_s = IDLE;
                        cnt_nx_s   = 4'd0;
                    end else begin
                        cnt_nx_s = cnt_inc_s;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = 4'd0;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Output decode from the next state so key_held rises with PRESSED entry
    always_comb begin
        held_nx_s = 1'b0;
        if (state_nx_s == PRESSED) begin
            held_nx_s = 1'b1;
        end else begin
            held_nx_s = 1'b0;
        end
    end

    // Registered outputs: press event loading, acknowledge and overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            key_held_r <= held_nx_s;
            if (press_evt_s) begin
                if (!key_valid_r || key_ack) begin
                    key_code_r  <= cand_nx_s;
                    key_valid_r <= 1'b1;
                end else begin
                    overrun_r   <= 1'b1;
                end
            end else if (key_ack) begin
                key_valid_r <= 1'b0;
            end else begin
                key_valid_r <= key_valid_r;
            end
        end
    end

    assign col_out   = col_out_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a keypad matrix model drives the rows
// from a set of pressed keys, and a sweep-level reference model predicts the
// handshake outputs after every completed sweep.
module tb_keypad_scan;

    localparam int SD  = 4;
    localparam int DEB = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack = 1'b0;
    logic        key_held;
    logic        overrun;

    logic [15:0] pressed = 16'h0000;
    logic        force_low = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (key-level view of the scanner)
    int         m_state;   // 0 idle, 1 debouncing press, 2 held
    int         m_cand;
    int         m_cnt;
    logic       m_valid;
    logic [3:0] m_code;
    logic       m_held;
    logic       m_over;

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key shorts its row to its column when driven low
    always_comb begin
        row_in = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (pressed[c*4+r] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
        if (force_low) row_in = 4'b0000;
    end

    task automatic mdl_reset();
        m_state = 0; m_cand = 0; m_cnt = 0;
        m_valid = 1'b0; m_code = 4'h0; m_held = 1'b0; m_over = 1'b0;
    endtask

    // One sweep of the key-level rules: mid-sweep ack, then the sweep decision
    task automatic mdl_step(input logic [15:0] keys, input bit am, input bit ae);
        int n;
        int k;
        bit evt;
        n = $countones(keys);
        k = 0;
        for (int i = 0; i < 16; i++) if (keys[i]) k = i;
        if (am) m_valid = 1'b0;
        evt = 1'b0;
        if (m_state == 0) begin
            if (n == 1) begin
                m_cand = k;
                if (DEB == 1) begin m_state = 2; m_cnt = 0; evt = 1'b1; end
                else begin m_state = 1; m_cnt = 1; end
            end
        end else if (m_state == 1) begin
            if (n == 1 && k == m_cand) begin
                m_cnt++;
                if (m_cnt == DEB) begin m_state = 2; m_cnt = 0; evt = 1'b1; end
            end else if (n == 1) begin
                m_cand = k; m_cnt = 1;
            end else begin
                m_state = 0; m_cnt = 0;
            end
        end else begin
            if (n == 1 && k == m_cand) m_cnt = 0;
            else begin
                m_cnt++;
                if (m_cnt == DEB) begin m_state = 0; m_cnt = 0; end
            end
        end
        if (evt) begin
            if (!m_valid || ae) begin m_code = 4'(m_cand); m_valid = 1'b1; end
            else m_over = 1'b1;
        end else if (ae) begin
            m_valid = 1'b0;
        end
        m_held = (m_state == 2);
    endtask

    // Drive one sweep aligned to the DUT's sweep-decision edge; ends #1 after it
    task automatic do_sweep(input logic [15:0] keys, input bit am, input bit ae);
        pressed = keys;
        for (int e = 1; e <= 16; e++) begin
            key_ack = (e == 8) ? am : ((e == 16) ? ae : 1'b0);
            @(posedge clk);
            #1;
        end
        key_ack = 1'b0;
        mdl_step(keys, am, ae);
    endtask

    // Reset and align: ends #1 after the first edge following release
    task automatic reset_dut();
        rst_n = 1'b0;
        #12;
        mdl_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        force_low = 1'b1;
        rst_n = 1'b0;
        #23;
        n_tests++;
        if ({col_out, key_code, key_valid, key_held, overrun} !== {4'b1110, 4'h0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got col=%b code=%h v=%b h=%b o=%b, expected col=1110 code=0 v=0 h=0 o=0",
                     col_out, key_code, key_valid, key_held, overrun);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int e = 0; e <= 16; e++) begin
            if (e > 0) begin
                @(posedge clk);
                #1;
            end
            exp_col = ~(4'b0001 << ((e / 4) % 4));
            n_tests++;
            if (col_out !== exp_col) begin
                n_fail++;
                $display("FAIL col_sequence clk %0d: got %b, expected %b", e, col_out, exp_col);
            end
        end
        force_low = 1'b0;
    endtask

    task automatic test_clean_press();
        logic [15:0] ks [5];
        bit          am [5];
        ks = '{16'h0040, 16'h0040, 16'h0040, 16'h0000, 16'h0000};
        am = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            do_sweep(ks[i], am[i], 1'b0);
            n_tests++;
            if ({key_valid, key_code, key_held, overrun} !== {m_valid, m_code, m_held, m_over}) begin
                n_fail++;
                $display("FAIL clean_press sweep %0d: got {v,code,h,o}=%b, expected %b", i,
                         {key_valid, key_code, key_held, overrun}, {m_valid, m_code, m_held, m_over});
            end
            if (i == 1) begin
                n_tests++;
                if ({key_valid, key_code, key_held} !== {1'b1, 4'h6, 1'b1}) begin
                    n_fail++;
                    $display("FAIL clean_press_code: got v=%b code=%h h=%b, expected v=1 code=6 h=1",
                             key_valid, key_code, key_held);
                end
            end
        end
    endtask

    task automatic test_bounce();
        logic [15:0] ks [10];
        bit          am [10];
        ks = '{16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h0000,
               16'h8000, 16'h8000, 16'h0000, 16'h0000};
        am = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            do_sweep(ks[i], am[i], 1'b0);
            n_tests++;
            if ({key_valid, key_code, key_held, overrun} !== {m_valid, m_code, m_held, m_over}) begin
                n_fail++;
                $display("FAIL bounce sweep %0d: got {v,code,h,o}=%b, expected %b", i,
                         {key_valid, key_code, key_held, overrun}, {m_valid, m_code, m_held, m_over});
            end
        end
    endtask

    task automatic test_ghost_lockout();
        logic [15:0] ks [9];
        bit          am [9];
        ks = '{16'h0021, 16'h0021, 16'h0008, 16'h0008, 16'h0208, 16'h0208, 16'h0208,
               16'h0200, 16'h0200};
        am = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            do_sweep(ks[i], am[i], 1'b0);
            n_tests++;
            if ({key_valid, key_code, key_held, overrun} !== {m_valid, m_code, m_held, m_over}) begin
                n_fail++;
                $display("FAIL ghost_lockout sweep %0d: got {v,code,h,o}=%b, expected %b", i,
                         {key_valid, key_code, key_held, overrun}, {m_valid, m_code, m_held, m_over});
            end
        end
        n_tests++;
        if ({key_valid, key_code} !== {1'b1, 4'h9}) begin
            n_fail++;
            $display("FAIL ghost_late_key: got v=%b code=%h, expected v=1 code=9", key_valid, key_code);
        end
    endtask

    task automatic test_overrun();
        logic [15:0] ks [10];
        bit          ae [10];
        ks = '{16'h0002, 16'h0002, 16'h0000, 16'h0000, 16'h0004, 16'h0004,
               16'h0000, 16'h0000, 16'h0004, 16'h0004};
        ae = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            do_sweep(ks[i], 1'b0, ae[i]);
            n_tests++;
            if ({key_valid, key_code, key_held, overrun} !== {m_valid, m_code, m_held, m_over}) begin
                n_fail++;
                $display("FAIL overrun sweep %0d: got {v,code,h,o}=%b, expected %b", i,
                         {key_valid, key_code, key_held, overrun}, {m_valid, m_code, m_held, m_over});
            end
            if (i == 5) begin
                n_tests++;
                if ({key_code, overrun, key_valid} !== {4'h1, 1'b1, 1'b1}) begin
                    n_fail++;
                    $display("FAIL overrun_lost: got code=%h o=%b v=%b, expected code=1 o=1 v=1",
                             key_code, overrun, key_valid);
                end
            end
        end
        n_tests++;
        if ({key_code, key_valid} !== {4'h2, 1'b1}) begin
            n_fail++;
            $display("FAIL ack_on_event: got code=%h v=%b, expected code=2 v=1", key_code, key_valid);
        end
    endtask

    task automatic test_mid_reset();
        do_sweep(16'h0000, 1'b0, 1'b0);
        do_sweep(16'h0000, 1'b0, 1'b0);
        do_sweep(16'h0080, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        n_tests++;
        if (col_out !== 4'b1011) begin
            n_fail++;
            $display("FAIL mid_reset_col2: got %b, expected 1011", col_out);
        end
        rst_n = 1'b0;
        #2;
        n_tests++;
        if ({col_out, key_code, key_valid, key_held, overrun} !== {4'b1110, 4'h0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_values: got col=%b code=%h v=%b h=%b o=%b, expected col=1110 code=0 v=0 h=0 o=0",
                     col_out, key_code, key_valid, key_held, overrun);
        end
        mdl_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            do_sweep(16'h0080, 1'b0, 1'b0);
            n_tests++;
            if ({key_valid, key_code, key_held} !== ((i == 0) ? {1'b0, 4'h0, 1'b0} : {1'b1, 4'h7, 1'b1})) begin
                n_fail++;
                $display("FAIL mid_reset_accept sweep %0d: got v=%b code=%h h=%b", i, key_valid, key_code, key_held);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] keys;
        int          pick;
        bit          am;
        bit          ae;
        reset_dut();
        keys = 16'h0000;
        for (int i = 0; i < 48; i++) begin
            pick = $urandom_range(0, 9);
            if (pick < 4) begin
                keys = keys;
            end else if (pick < 6) begin
                keys = 16'h0000;
            end else if (pick < 9) begin
                keys = 16'h0001 << $urandom_range(0, 15);
            end else begin
                keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            end
            am = ($urandom_range(0, 3) == 0);
            ae = ($urandom_range(0, 3) == 0);
            do_sweep(keys, am, ae);
            n_tests++;
            if ({key_valid, key_code, key_held, overrun} !== {m_valid, m_code, m_held, m_over}) begin
                n_fail++;
                $display("FAIL random sweep %0d keys=%h: got {v,code,h,o}=%b, expected %b", i, keys,
                         {key_valid, key_code, key_held, overrun}, {m_valid, m_code, m_held, m_over});
            end
        end
    endtask

    initial begin
        mdl_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_ghost_lockout();
        test_overrun();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
